// File: rtl/bcd_to_bin_conv.sv
// Sequential BCD-to-binary converter using reverse double-dabble, one bit per clock.
// A start/busy/done handshake wraps the iteration; invalid digits are rejected without converting.
module bcd_to_bin_conv #(
   parameter int DIGITS = 4,
   parameter int BIN_W  = 14
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   bcd,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [BIN_W-1:0]      bin
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_CONV = 1'b1
   } state_t;

   function automatic logic bcd_valid(input logic [BCD_W-1:0] v);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         ok = ok & (v[4*i +: 4] <= 4'd9);
      end
      return ok;
   endfunction

   // Digits that reached 8 or more after the shift held a carried-in half; pull 3 back out.
   function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] v);
      logic [BCD_W-1:0] r;
      r = v;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] >= 4'd8) begin
            r[4*i +: 4] = v[4*i +: 4] - 4'd3;
         end else begin
            r[4*i +: 4] = v[4*i +: 4];
         end
      end
      return r;
   endfunction

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BCD_W-1:0]   bcd_sh_q, bcd_sh_d;
   logic [BIN_W-1:0]   bin_sh_q, bin_sh_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic [BIN_W-1:0]   bin_q, bin_d;

   logic [BCD_W-1:0]   bcd_shift_s;
   logic [BIN_W-1:0]   bin_shift_s;

   assign {bcd_shift_s, bin_shift_s} = {1'b0, bcd_sh_q, bin_sh_q[BIN_W-1:1]};

   // Next-state and output logic for the IDLE/CONV handshake.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bcd_sh_d = bcd_sh_q;
      bin_sh_d = bin_sh_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      err_d    = err_q;
      bin_d    = bin_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (bcd_valid(bcd)) begin
                  bcd_sh_d = bcd;
                  bin_sh_d = {BIN_W{1'b0}};
                  cnt_d    = {CNT_W{1'b0}};
                  busy_d   = 1'b1;
                  state_d  = ST_CONV;
               end else begin
                  bin_d  = {BIN_W{1'b0}};
                  err_d  = 1'b1;
                  done_d = 1'b1;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CONV: begin
            bcd_sh_d = bcd_adjust(bcd_shift_s);
            bin_sh_d = bin_shift_s;
            if (cnt_q == CNT_LAST) begin
               bin_d   = bin_shift_s;
               err_d   = 1'b0;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= {CNT_W{1'b0}};
         bcd_sh_q <= {BCD_W{1'b0}};
         bin_sh_q <= {BIN_W{1'b0}};
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         bin_q    <= {BIN_W{1'b0}};
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bcd_sh_q <= bcd_sh_d;
         bin_sh_q <= bin_sh_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
         bin_q    <= bin_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign err  = err_q;
   assign bin  = bin_q;

endmodule
